// File: rtl/bb_rst_pkg.sv
// Shared types and constants for the reset generator cell.
//   state_e         : FSM state (ACTIVE, HOLD, RUN), 2-bit encoding
//   HOLD_CYCLES_DEF : default stretch length after the last request
//   CNT_W_DEF       : default hold counter width
//   SEL_FUNC/BYPASS : meaning of the downstream mux select
package bb_rst_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int unsigned HOLD_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 8;

  localparam logic SEL_FUNC   = 1'b0;
  localparam logic SEL_BYPASS = 1'b1;

endpackage

// File: rtl/bb_hold_cnt.sv
// Hold counter for the reset stretcher.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (wins over en)
//   en       : increment by one
//   tc_c     : combinational terminal count, high when count == HOLD_CYCLES-1
// The count is only ever compared for equality and the parent clears it on
// every restart, so it never wraps.
module bb_hold_cnt
  import bb_rst_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == TC_VAL);

endmodule

// File: rtl/bb_rst_gen_cell.sv
// Reset generator feeding a reset/clock mux cell.
//   clk, rst     : clock, synchronous active-high reset
//   rst_req      : level reset request
//   sw_rst_pulse : one-cycle soft reset request (a level acts as a level)
//   test_mode    : requested mux select (1 = bypass, 0 = functional)
//   rst_out      : stretched reset, registered, active-high
//   mux_sel      : registered select; only moves while rst_out is held high
//   busy         : registered, high whenever the FSM is not in RUN
//   rel_pulse    : registered, high in the first cycle rst_out is low
module bb_rst_gen_cell
  import bb_rst_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_req,
  input  logic sw_rst_pulse,
  input  logic test_mode,
  output logic rst_out,
  output logic mux_sel,
  output logic busy,
  output logic rel_pulse
);

  // Reject hold lengths the counter cannot reach.
  if ((HOLD_CYCLES < 1) || (64'(HOLD_CYCLES) >= (64'(1) << CNT_W))) begin : g_bad_hold
    $error("bb_rst_gen_cell: HOLD_CYCLES must be in 1..2**CNT_W-1");
  end

  state_e state_q;
  state_e state_d;
  logic   mux_sel_d;
  logic   sel_diff_c;
  logic   any_req_c;
  logic   cnt_clr_c;
  logic   cnt_en_c;
  logic   tc_c;

  assign sel_diff_c = (test_mode != mux_sel);
  assign any_req_c  = rst_req | sw_rst_pulse | sel_diff_c;

  bb_hold_cnt #(
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_c),
    .en   (cnt_en_c),
    .tc_c (tc_c)
  );

  // Next state, next select and counter control.
  // Priority inside HOLD: rst_req > sw_rst_pulse > select change > expiry.
  always_comb begin
    state_d   = state_q;
    mux_sel_d = mux_sel;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;
    unique case (state_q)
      ST_ACTIVE: begin
        // Select tracks the request freely: rst_out is high on both sides.
        mux_sel_d = test_mode;
        cnt_clr_c = 1'b1;
        if (!rst_req) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rst_req) begin
          state_d   = ST_ACTIVE;
          cnt_clr_c = 1'b1;
        end else if (sw_rst_pulse) begin
          cnt_clr_c = 1'b1;
        end else if (sel_diff_c) begin
          mux_sel_d = test_mode;
          cnt_clr_c = 1'b1;
        end else if (tc_c) begin
          state_d   = ST_RUN;
          cnt_clr_c = 1'b1;
        end else begin
          cnt_en_c = 1'b1;
        end
      end
      ST_RUN: begin
        // Select is frozen here; a pending change is taken in ACTIVE.
        cnt_clr_c = 1'b1;
        if (any_req_c) begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d   = ST_ACTIVE;
        cnt_clr_c = 1'b1;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACTIVE;
      rst_out   <= 1'b1;
      mux_sel   <= SEL_FUNC;
      busy      <= 1'b1;
      rel_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_out   <= (state_d != ST_RUN);
      mux_sel   <= mux_sel_d;
      busy      <= (state_d != ST_RUN);
      rel_pulse <= (state_q != ST_RUN) && (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_bb_rst_gen_cell.sv
// Bench for bb_rst_gen_cell: run-length vector table on a HOLD_CYCLES=16
// instance, hand sequences for reset corners, and a HOLD_CYCLES=1 instance.
module tb_bb_rst_gen_cell;
  import bb_rst_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // HOLD_CYCLES = 16 instance
  logic rst, rst_req, sw_rst_pulse, test_mode;
  logic rst_out, mux_sel, busy, rel_pulse;

  // HOLD_CYCLES = 1 instance
  logic rst_1, rst_req_1, sw_1, tm_1;
  logic ro_1, ms_1, bz_1, rp_1;

  bb_rst_gen_cell #(.HOLD_CYCLES(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_req      (rst_req),
    .sw_rst_pulse (sw_rst_pulse),
    .test_mode    (test_mode),
    .rst_out      (rst_out),
    .mux_sel      (mux_sel),
    .busy         (busy),
    .rel_pulse    (rel_pulse)
  );

  bb_rst_gen_cell #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk          (clk),
    .rst          (rst_1),
    .rst_req      (rst_req_1),
    .sw_rst_pulse (sw_1),
    .test_mode    (tm_1),
    .rst_out      (ro_1),
    .mux_sel      (ms_1),
    .busy         (bz_1),
    .rel_pulse    (rp_1)
  );

  typedef struct packed {
    logic ro;
    logic ms;
    logic bz;
    logic rp;
  } exp_t;

  // Inputs held for n cycles; each of those cycles expects the same outputs.
  typedef struct {
    logic r;
    logic q;
    logic s;
    logic t;
    int   n;
    logic ro;
    logic ms;
    logic rp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string what, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step%0d: got %0h, expected %0h", what, idx, act, exp);
    end
  endtask

  // busy and rst_out both mean "not in RUN", so they share one expectation.
  task automatic v(input logic r, q, s, t, input int n, input logic ro, ms, rp);
    vec_t x;
    x = '{r, q, s, t, n, ro, ms, rp};
    vecs.push_back(x);
  endtask

  // One cycle on the 16-cycle instance, with the live-select invariant.
  task automatic step(input int idx, input logic r, q, s, t, input exp_t e);
    exp_t got;
    logic pro, pms;
    rst = r; rst_req = q; sw_rst_pulse = s; test_mode = t;
    sb.push_back(e);
    pro = rst_out;
    pms = mux_sel;
    @(posedge clk); #1;
    got = sb.pop_front();
    chk("rst_out",   idx, 8'(rst_out),   8'(got.ro));
    chk("mux_sel",   idx, 8'(mux_sel),   8'(got.ms));
    chk("busy",      idx, 8'(busy),      8'(got.bz));
    chk("rel_pulse", idx, 8'(rel_pulse), 8'(got.rp));
    if (!r) begin
      tests++;
      if ((mux_sel !== pms) && !(pro && rst_out)) begin
        fails++;
        $display("FAIL mux_sel_live_toggle step%0d: rst_out %0b->%0b while mux_sel %0b->%0b",
                 idx, pro, rst_out, pms, mux_sel);
      end
    end
  endtask

  // One cycle on the 1-cycle instance.
  task automatic step1(input int idx, input logic r, q, s, input logic ero, erp);
    exp_t got;
    exp_t e;
    rst_1 = r; rst_req_1 = q; sw_1 = s; tm_1 = 1'b0;
    e = '{ero, 1'b0, ero, erp};
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    chk("h1_rst_out",   idx, 8'(ro_1), 8'(got.ro));
    chk("h1_mux_sel",   idx, 8'(ms_1), 8'(got.ms));
    chk("h1_busy",      idx, 8'(bz_1), 8'(got.bz));
    chk("h1_rel_pulse", idx, 8'(rp_1), 8'(got.rp));
  endtask

  initial begin
    int idx;
    rst = 1'b1; rst_req = 1'b0; sw_rst_pulse = 1'b0; test_mode = 1'b0;
    rst_1 = 1'b1; rst_req_1 = 1'b0; sw_1 = 1'b0; tm_1 = 1'b0;

    //     r  q  s  t   n  ro ms rp
    // power-up: reset values, 16 held cycles, release
    v(1, 0, 0, 0,  3, 1, 0, 0);
    v(0, 0, 0, 0, 16, 1, 0, 0);
    v(0, 0, 0, 0,  1, 0, 0, 1);
    v(0, 0, 0, 0,  3, 0, 0, 0);
    // rst_req high for 5 cycles from RUN
    v(0, 1, 0, 0,  5, 1, 0, 0);
    v(0, 0, 0, 0, 16, 1, 0, 0);
    v(0, 0, 0, 0,  1, 0, 0, 1);
    v(0, 0, 0, 0,  2, 0, 0, 0);
    // single sw pulse: one ACTIVE + 16 HOLD
    v(0, 0, 1, 0,  1, 1, 0, 0);
    v(0, 0, 0, 0, 16, 1, 0, 0);
    v(0, 0, 0, 0,  1, 0, 0, 1);
    v(0, 0, 0, 0,  2, 0, 0, 0);
    // sw pulse, second pulse at hold count 10 restarts count
    v(0, 0, 1, 0,  1, 1, 0, 0);
    v(0, 0, 0, 0, 11, 1, 0, 0);
    v(0, 0, 1, 0,  1, 1, 0, 0);
    v(0, 0, 0, 0, 15, 1, 0, 0);
    v(0, 0, 0, 0,  1, 0, 0, 1);
    v(0, 0, 0, 0,  2, 0, 0, 0);
    // test_mode 0->1 in RUN: select moves one cycle after rst_out rises
    v(0, 0, 0, 1,  1, 1, 0, 0);
    v(0, 0, 0, 1,  1, 1, 1, 0);
    v(0, 0, 0, 1, 15, 1, 1, 0);
    v(0, 0, 0, 1,  1, 0, 1, 1);
    v(0, 0, 0, 1,  2, 0, 1, 0);
    // test_mode 1->0 in RUN
    v(0, 0, 0, 0,  1, 1, 1, 0);
    v(0, 0, 0, 0,  1, 1, 0, 0);
    v(0, 0, 0, 0, 15, 1, 0, 0);
    v(0, 0, 0, 0,  1, 0, 0, 1);
    v(0, 0, 0, 0,  2, 0, 0, 0);
    // test_mode change at hold count 5 applies in HOLD and restarts count
    v(0, 0, 1, 0,  1, 1, 0, 0);
    v(0, 0, 0, 0,  6, 1, 0, 0);
    v(0, 0, 0, 1,  1, 1, 1, 0);
    v(0, 0, 0, 1, 15, 1, 1, 0);
    v(0, 0, 0, 1,  1, 0, 1, 1);
    v(0, 0, 0, 1,  1, 0, 1, 0);
    // reach hold count 7 with mux_sel = 1
    v(0, 0, 1, 1,  1, 1, 1, 0);
    v(0, 0, 0, 1,  8, 1, 1, 0);

    idx = 0;
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        step(idx, vecs[i].r, vecs[i].q, vecs[i].s, vecs[i].t,
             '{vecs[i].ro, vecs[i].ms, vecs[i].ro, vecs[i].rp});
        idx++;
      end
    end

    // rst at hold count 7: reset values next cycle, select back to functional
    step(idx, 1'b1, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b1, 1'b0}); idx++;
    chk("state_after_rst", idx, 8'(dut.state_q), 8'(ST_ACTIVE));
    chk("cnt_after_rst",   idx, 8'(dut.u_cnt.cnt_q), 8'(0));
    // test_mode still 1: honoured by the first ACTIVE cycle
    step(idx, 1'b0, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b1, 1'b1, 1'b0}); idx++;
    for (int k = 0; k < 15; k++) begin
      step(idx, 1'b0, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b1, 1'b1, 1'b0}); idx++;
    end
    step(idx, 1'b0, 1'b0, 1'b0, 1'b1, '{1'b0, 1'b1, 1'b0, 1'b1}); idx++;
    // rst mid-RUN with mux_sel = 1
    step(idx, 1'b1, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b1, 1'b0}); idx++;
    step(idx, 1'b0, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b1, 1'b1, 1'b0}); idx++;

    // HOLD_CYCLES = 1: release two cycles after rst_req sampled low
    step1(100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step1(101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step1(102, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step1(103, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step1(104, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step1(105, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // rst_req and sw_rst_pulse together in HOLD: rst_req wins
    step1(106, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("h1_state_req_wins", 106, 8'(dut1.state_q), 8'(ST_ACTIVE));
    step1(107, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step1(108, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
